// File: rtl/lms_coef_if.sv
// Bundle between the FFE host/slicer logic and the LMS coefficient engine.
// The engine uses the slave view; the driving side uses the master view.
interface lms_coef_if #(
   parameter int DATA_BW = 11,
   parameter int ERR_BW  = 8,
   parameter int COEF_BW = 9,
   parameter int N_COEF  = 7
);
   localparam int IDX_BW = (N_COEF > 1) ? $clog2(N_COEF) : 1;

   logic                      i_en;
   logic [DATA_BW-1:0]        i_data;
   logic [ERR_BW-1:0]         i_error;
   logic [ERR_BW-1:0]         i_mu;
   logic                      i_freeze;
   logic                      i_leak_en;
   logic                      i_load;
   logic [IDX_BW-1:0]         i_load_idx;
   logic [COEF_BW-1:0]        i_load_val;
   logic                      i_clr_sat;
   logic [COEF_BW*N_COEF-1:0] o_coefs;
   logic [N_COEF-1:0]         o_sat;

   modport master (
      output i_en, i_data, i_error, i_mu, i_freeze, i_leak_en,
      output i_load, i_load_idx, i_load_val, i_clr_sat,
      input  o_coefs, o_sat
   );

   modport slave (
      input  i_en, i_data, i_error, i_mu, i_freeze, i_leak_en,
      input  i_load, i_load_idx, i_load_val, i_clr_sat,
      output o_coefs, o_sat
   );
endinterface

// File: rtl/lms_coef_engine.sv
// LMS coefficient updater for the adaptive FFE: c[k] += mu*e*x[k] with saturating
// accumulators, optional leakage, freeze, host load and rounded/saturated outputs.
module lms_coef_engine #(
   parameter int DATA_BW    = 11,
   parameter int DATA_FBW   = 7,
   parameter int ERR_BW     = 8,
   parameter int COEF_BW    = 9,
   parameter int COEF_FBW   = 7,
   parameter int ACC_BW     = 27,
   parameter int N_COEF     = 7,
   parameter int CENTER     = N_COEF / 2,
   parameter int LEAK_SHIFT = 12
) (
   input logic       i_clk,
   input logic       i_rst,
   lms_coef_if.slave bus
);
   localparam int ACC_FBW = 2 * (ERR_BW - 1) + DATA_FBW;
   localparam int SHIFT   = ACC_FBW - COEF_FBW;
   localparam int EW_BW   = 2 * ERR_BW;
   localparam int CORR_BW = EW_BW + DATA_BW;
   localparam int SUM_BW  = ((ACC_BW > CORR_BW) ? ACC_BW : CORR_BW) + 2;
   localparam int RND_BW  = ACC_BW + 1 - SHIFT;
   localparam int IDX_BW  = (N_COEF > 1) ? $clog2(N_COEF) : 1;

   localparam logic signed [ACC_BW-1:0]  ACC_MAX  = {1'b0, {(ACC_BW-1){1'b1}}};
   localparam logic signed [ACC_BW-1:0]  ACC_MIN  = {1'b1, {(ACC_BW-1){1'b0}}};
   localparam logic signed [SUM_BW-1:0]  SUM_MAX  = {{(SUM_BW-ACC_BW){1'b0}}, ACC_MAX};
   localparam logic signed [SUM_BW-1:0]  SUM_MIN  = {{(SUM_BW-ACC_BW){1'b1}}, ACC_MIN};
   localparam logic signed [ACC_BW-1:0]  ACC_ONE  =
      {{(ACC_BW-ACC_FBW-1){1'b0}}, 1'b1, {ACC_FBW{1'b0}}};
   localparam logic signed [COEF_BW-1:0] COEF_ONE =
      {{(COEF_BW-COEF_FBW-1){1'b0}}, 1'b1, {COEF_FBW{1'b0}}};
   localparam logic signed [ACC_BW:0]    RND_HALF =
      {{(ACC_BW-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
   localparam logic signed [RND_BW-1:0]  CMAX = {{(RND_BW-COEF_BW+1){1'b0}}, {(COEF_BW-1){1'b1}}};
   localparam logic signed [RND_BW-1:0]  CMIN = {{(RND_BW-COEF_BW+1){1'b1}}, {(COEF_BW-1){1'b0}}};

   logic signed [DATA_BW-1:0] r_dl [N_COEF];
   logic signed [EW_BW-1:0]   r_ew;
   logic signed [EW_BW-1:0]   w_err_x;
   logic signed [EW_BW-1:0]   w_mu_x;
   logic                      w_upd_en;

   assign w_err_x  = {{ERR_BW{bus.i_error[ERR_BW-1]}}, bus.i_error};
   assign w_mu_x   = {{ERR_BW{bus.i_mu[ERR_BW-1]}}, bus.i_mu};
   assign w_upd_en = bus.i_en & ~bus.i_freeze;

   // ew is captured every clock; the update uses the value held from the previous clock.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ew <= '0;
         for (int k = 0; k < N_COEF; k++) r_dl[k] <= '0;
      end else begin
         r_ew <= w_err_x * w_mu_x;
         if (bus.i_en) begin
            r_dl[0] <= bus.i_data;
            for (int k = 1; k < N_COEF; k++) r_dl[k] <= r_dl[k-1];
         end
      end
   end

   for (genvar k = 0; k < N_COEF; k++) begin : g_tap
      localparam logic signed [ACC_BW-1:0]  ACC_RST  = (k == CENTER) ? ACC_ONE : '0;
      localparam logic signed [COEF_BW-1:0] COEF_RST = (k == CENTER) ? COEF_ONE : '0;

      logic signed [ACC_BW-1:0]  r_acc;
      logic signed [COEF_BW-1:0] r_coef;
      logic                      r_sat;
      logic signed [CORR_BW-1:0] w_ew_x, w_dl_x, w_corr;
      logic signed [ACC_BW-1:0]  w_leak, w_upd, w_load_acc;
      logic signed [SUM_BW-1:0]  w_sum;
      logic                      w_ovf_hi, w_ovf_lo, w_load_hit;
      logic signed [ACC_BW:0]    w_rnd;
      logic signed [RND_BW-1:0]  w_shf;
      logic signed [COEF_BW-1:0] w_coef;
      logic [SHIFT-1:0]          w_unused_frac;

      assign w_ew_x = {{(CORR_BW-EW_BW){r_ew[EW_BW-1]}}, r_ew};
      assign w_dl_x = {{(CORR_BW-DATA_BW){r_dl[k][DATA_BW-1]}}, r_dl[k]};
      assign w_corr = w_ew_x * w_dl_x;
      assign w_leak = bus.i_leak_en ? (r_acc >>> LEAK_SHIFT) : '0;

      // Sum is two bits wider than either operand so overflow is detected, never wrapped.
      assign w_sum = {{(SUM_BW-ACC_BW){r_acc[ACC_BW-1]}}, r_acc}
                   - {{(SUM_BW-ACC_BW){w_leak[ACC_BW-1]}}, w_leak}
                   + {{(SUM_BW-CORR_BW){w_corr[CORR_BW-1]}}, w_corr};
      assign w_ovf_hi = w_sum > SUM_MAX;
      assign w_ovf_lo = w_sum < SUM_MIN;
      assign w_upd    = w_ovf_hi ? ACC_MAX : (w_ovf_lo ? ACC_MIN : w_sum[ACC_BW-1:0]);

      assign w_load_hit = bus.i_load && (bus.i_load_idx == IDX_BW'(k));
      assign w_load_acc = {{(ACC_BW-COEF_BW-SHIFT){bus.i_load_val[COEF_BW-1]}},
                           bus.i_load_val, {SHIFT{1'b0}}};

      assign w_rnd         = {r_acc[ACC_BW-1], r_acc} + RND_HALF;
      assign w_shf         = w_rnd[ACC_BW:SHIFT];
      assign w_unused_frac = w_rnd[SHIFT-1:0];
      assign w_coef = (w_shf > CMAX) ? CMAX[COEF_BW-1:0] :
                      (w_shf < CMIN) ? CMIN[COEF_BW-1:0] : w_shf[COEF_BW-1:0];

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_acc  <= ACC_RST;
            r_coef <= COEF_RST;
            r_sat  <= 1'b0;
         end else begin
            if (w_load_hit)    r_acc <= w_load_acc;
            else if (w_upd_en) r_acc <= w_upd;
            r_coef <= w_coef;
            r_sat  <= (r_sat & ~bus.i_clr_sat) |
                      (w_upd_en & ~w_load_hit & (w_ovf_hi | w_ovf_lo));
         end
      end

      assign bus.o_coefs[COEF_BW*k +: COEF_BW] = r_coef;
      assign bus.o_sat[k]                      = r_sat;
   end
endmodule

// File: tb/tb_lms_coef_engine.sv
// Directed bench for lms_coef_engine: expectations are queued as stimulus is driven
// and popped against the outputs once the engine has produced them.
module tb_lms_coef_engine;
   localparam int CB = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lms_coef_if #(.DATA_BW(11), .ERR_BW(8), .COEF_BW(9), .N_COEF(7)) bus ();

   lms_coef_engine dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // kind: 0 = all coefs, 1 = o_sat, 2 = single tap, 3 = internal accumulator
   typedef struct {
      string       tag;
      int          kind;
      int          idx;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input string tag, input int kind, input int idx, input logic [63:0] val);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.idx  = idx;
      e.val  = val;
      sb.push_back(e);
   endtask

   function automatic logic [63:0] pk(input int c0, input int c1, input int c2, input int c3,
                                      input int c4, input int c5, input int c6);
      return {1'b0, 9'(c6), 9'(c5), 9'(c4), 9'(c3), 9'(c2), 9'(c1), 9'(c0)};
   endfunction

   function automatic logic [63:0] get_acc(input int k);
      case (k)
         0:       return 64'(dut.g_tap[0].r_acc);
         1:       return 64'(dut.g_tap[1].r_acc);
         2:       return 64'(dut.g_tap[2].r_acc);
         3:       return 64'(dut.g_tap[3].r_acc);
         4:       return 64'(dut.g_tap[4].r_acc);
         5:       return 64'(dut.g_tap[5].r_acc);
         6:       return 64'(dut.g_tap[6].r_acc);
         default: return 64'd0;
      endcase
   endfunction

   task automatic drain();
      exp_t        e;
      logic [63:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            0:       obs = {1'b0, bus.o_coefs};
            1:       obs = {57'd0, bus.o_sat};
            2:       obs = {55'd0, bus.o_coefs[CB*e.idx +: CB]};
            default: obs = get_acc(e.idx);
         endcase
         n_vec++;
         assert (obs === e.val)
         else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.i_en       = 1'b0;
      bus.i_data     = '0;
      bus.i_error    = '0;
      bus.i_mu       = '0;
      bus.i_freeze   = 1'b0;
      bus.i_leak_en  = 1'b0;
      bus.i_load     = 1'b0;
      bus.i_load_idx = '0;
      bus.i_load_val = '0;
      bus.i_clr_sat  = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] rst_v;
      longint      a;
      longint      m;
      rst_v = pk(0, 0, 0, 128, 0, 0, 0);

      // Reset state, then held with i_en low
      do_reset();
      push("rst_coefs", 0, 0, rst_v);
      push("rst_sat", 1, 0, 64'd0);
      push("rst_acc3", 3, 3, 64'd2097152);
      drain();
      tick(3);
      push("hold_coefs", 0, 0, rst_v);
      push("hold_sat", 1, 0, 64'd0);
      drain();

      // Single update: 1.0 * 0.5 * 0.5 into tap 0
      bus.i_data = 11'd128; bus.i_en = 1'b1;
      tick(1);
      bus.i_en = 1'b0; bus.i_error = 8'd64; bus.i_mu = 8'd64;
      tick(1);
      bus.i_en = 1'b1; bus.i_data = 11'd0;
      push("upd_acc0", 3, 0, 64'd524288);
      tick(1);
      drain();
      bus.i_en = 1'b0; bus.i_error = 8'd0; bus.i_mu = 8'd0;
      push("upd_coefs", 0, 0, pk(32, 0, 0, 128, 0, 0, 0));
      tick(1);
      drain();

      // Freeze: no update, delay line still shifts (seen on tap 1 after unfreeze)
      do_reset();
      bus.i_freeze = 1'b1;
      bus.i_data = 11'd128; bus.i_en = 1'b1;
      tick(1);
      bus.i_en = 1'b0; bus.i_error = 8'd64; bus.i_mu = 8'd64;
      tick(1);
      bus.i_en = 1'b1; bus.i_data = 11'd0;
      tick(1);
      bus.i_en = 1'b0;
      push("frz_coefs", 0, 0, rst_v);
      tick(1);
      drain();
      bus.i_freeze = 1'b0; bus.i_en = 1'b1;
      push("unfrz_acc1", 3, 1, 64'd524288);
      push("unfrz_acc0", 3, 0, 64'd0);
      tick(1);
      drain();
      bus.i_en = 1'b0; bus.i_error = 8'd0; bus.i_mu = 8'd0;
      push("unfrz_coefs", 0, 0, pk(0, 32, 0, 128, 0, 0, 0));
      tick(1);
      drain();

      // Saturation with continuous updates
      do_reset();
      bus.i_data = 11'd1023; bus.i_error = 8'd127; bus.i_mu = 8'd127; bus.i_en = 1'b1;
      tick(3);
      push("sat_tap0_clip", 2, 0, 64'h0FF);
      push("sat_flag_early", 1, 0, 64'd0);
      drain();
      tick(7);
      push("sat_flags", 1, 0, 64'h1F);
      push("sat_acc0_max", 3, 0, 64'd67108863);
      push("sat_tap0_hold", 2, 0, 64'h0FF);
      drain();
      bus.i_clr_sat = 1'b1;
      push("sat_set_wins", 1, 0, 64'h3F);
      tick(1);
      drain();
      bus.i_en = 1'b0;
      push("sat_cleared", 1, 0, 64'd0);
      push("sat_tap0_nowrap", 2, 0, 64'h0FF);
      tick(1);
      drain();
      bus.i_clr_sat = 1'b0;

      // Leakage: centre tap decays, zero taps stay zero
      do_reset();
      bus.i_leak_en = 1'b1; bus.i_en = 1'b1;
      push("leak_acc3_first", 3, 3, 64'd2096640);
      push("leak_acc2_zero", 3, 2, 64'd0);
      tick(1);
      drain();
      tick(299);
      bus.i_en = 1'b0;
      a = 64'sd2097152;
      for (int i = 0; i < 300; i++) a = a - (a >>> 12);
      m = (a + 64'sd8192) >>> 14;
      if (m > 255) m = 255;
      push("leak_coefs", 0, 0, pk(0, 0, 0, int'(m), 0, 0, 0));
      tick(1);
      drain();
      bus.i_leak_en = 1'b0;

      // Host load: wins over a concurrent update on its tap, bad index ignored
      do_reset();
      bus.i_data = 11'd128; bus.i_en = 1'b1;
      tick(6);
      bus.i_en = 1'b0; bus.i_data = 11'd0; bus.i_error = 8'd64; bus.i_mu = 8'd64;
      tick(1);
      bus.i_en = 1'b1; bus.i_load = 1'b1; bus.i_load_idx = 3'd5; bus.i_load_val = 9'h1C0;
      tick(1);
      bus.i_en = 1'b0; bus.i_load = 1'b0; bus.i_error = 8'd0; bus.i_mu = 8'd0;
      push("load_coefs", 0, 0, pk(32, 32, 32, 160, 32, 'h1C0, 0));
      tick(1);
      drain();
      bus.i_load = 1'b1; bus.i_load_idx = 3'd7; bus.i_load_val = 9'h055;
      tick(1);
      bus.i_load = 1'b0;
      push("load_bad_idx", 0, 0, pk(32, 32, 32, 160, 32, 'h1C0, 0));
      tick(1);
      drain();
      bus.i_freeze = 1'b1; bus.i_en = 1'b1;
      bus.i_load = 1'b1; bus.i_load_idx = 3'd0; bus.i_load_val = 9'h0AB;
      tick(1);
      bus.i_load = 1'b0; bus.i_en = 1'b0;
      push("load_lat1_tap0", 2, 0, 64'h020);
      drain();
      push("load_frz_tap0", 2, 0, 64'h0AB);
      tick(1);
      drain();
      bus.i_freeze = 1'b0;

      // Reset mid-operation overrides all other inputs
      bus.i_en = 1'b1; bus.i_data = 11'd1023; bus.i_error = 8'd127; bus.i_mu = 8'd127;
      bus.i_load = 1'b1; bus.i_load_idx = 3'd3; bus.i_load_val = 9'h0FF;
      rst = 1'b1;
      tick(1);
      do_reset();
      push("midrst_coefs", 0, 0, rst_v);
      push("midrst_sat", 1, 0, 64'd0);
      push("midrst_acc0", 3, 0, 64'd0);
      tick(1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/lms_coef_engine.md
Name: lms_coef_engine

Overview:
Parametrised LMS coefficient-update engine for the adaptive FFE. It keeps an N_COEF-tap data delay line and updates every tap as c[k] += mu·e·x[k], with saturating accumulators. It adds optional leakage, freeze, per-tap host load, and rounded, saturated coefficient outputs. It feeds the FIR equaliser's coefficient bus and replaces the fixed 7-tap, truncate-only updater.

Parameters:
DATA_BW, 11, input sample width; format S(DATA_BW,DATA_FBW)
DATA_FBW, 7, sample fraction bits
ERR_BW, 8, error and mu width; both are S(ERR_BW,ERR_BW-1)
COEF_BW, 9, output coefficient width; format S(COEF_BW,COEF_FBW)
COEF_FBW, 7, output fraction bits
ACC_BW, 27, accumulator width; fraction ACC_FBW = 2·(ERR_BW-1)+DATA_FBW (21 at defaults)
N_COEF, 7, number of taps (≥1)
CENTER, N_COEF/2, tap initialised to 1.0 at reset
LEAK_SHIFT, 12, leakage shift

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_en  in  1  symbol strobe: shift the delay line and update coefficients
i_data  in  DATA_BW  input sample
i_error  in  ERR_BW  slicer error
i_mu  in  ERR_BW  step size
i_freeze  in  1  block coefficient updates; the delay line still shifts
i_leak_en  in  1  enable leakage
i_load  in  1  host write of one coefficient
i_load_idx  in  clog2(N_COEF)  tap index for the write
i_load_val  in  COEF_BW  value in coefficient format
i_clr_sat  in  1  clear the sticky saturation flags
o_coefs  out  COEF_BW·N_COEF  tap k occupies bits [COEF_BW·(k+1)-1 : COEF_BW·k]
o_sat  out  N_COEF  sticky per-tap accumulator saturation flags

Behaviour:
- Reset is synchronous and active-high. On reset:
  - delay line = 0
  - ew = 0
  - acc[k] = 0, except acc[CENTER] = 2^ACC_FBW (1.0)
  - o_coefs: all 0 except tap CENTER = 2^COEF_FBW
  - o_sat = 0
  Reset asserted mid-operation overrides every other input in that cycle.
- Delay line dl[0..N_COEF-1]: on i_en, dl[0]<=i_data and dl[k]<=dl[k-1].
- Stage 1: ew <= i_error·i_mu on every clock, independent of i_en. Width 2·ERR_BW, fraction 2·(ERR_BW-1).
- Stage 2: corr[k] = ew·dl[k]. Uses dl values from before any shift in the same cycle.
- leak[k] = acc[k] >>> LEAK_SHIFT (arithmetic shift) when i_leak_en = 1, else 0.
- Update when i_en=1 and i_freeze=0: sum = acc[k] - leak[k] + corr[k], computed at full width with no wrap.
  - If sum exceeds the ACC_BW signed range, acc[k] clamps to max or min and o_sat[k] is set.
  - Otherwise acc[k] = sum.
- Host load:
  - i_load writes acc[i_load_idx] = sign-extended i_load_val << (ACC_FBW-COEF_FBW).
  - Load has priority over update for that tap. Other taps update normally in the same cycle.
  - An out-of-range idx is ignored.
  - Load works while frozen.
- o_sat:
  - Sticky until i_clr_sat or reset.
  - If saturation and i_clr_sat occur in the same cycle, set wins.
- Output conversion, registered:
  - o_coef[k] <= sat(round_half_up(acc[k] >> (ACC_FBW-COEF_FBW))).
  - Rounding adds 2^(ACC_FBW-COEF_FBW-1) before the shift.
  - The result saturates to [-2^(COEF_BW-1), 2^(COEF_BW-1)-1]. It never wraps.
- Latency:
  - i_error/i_mu to acc: 1 clock (captured in ew), then the next i_en edge.
  - acc to o_coefs: 1 clock.
  - i_load to o_coefs: 2 clocks.

Test Plan:
1. Reset with defaults -> o_coefs tap3 = 0x080, all other taps 0x000; o_sat = 0; outputs held while i_en = 0.
2. Single update: push 128 (1.0) with i_error = 0, then hold i_error = 64, i_mu = 64 for one clock with i_en = 0, then pulse i_en once -> acc[0] = 524288 (0.25); two clocks later tap0 = 0x020; other taps unchanged.
3. Saturation: hold dl[0] = 1023, i_error = 127, i_mu = 127, with i_en high continuously -> tap0 clamps at 0x0FF and stays there; after about 5 updates o_sat[0] = 1 and acc[0] = 2^26-1, never wrapping negative; i_clr_sat clears the flag only once saturation stops.
4. Freeze: same stimulus as scenario 2 with i_freeze = 1 -> coefficients unchanged; the delay line still shifts (verify via an update after unfreeze).
5. Leak: i_leak_en = 1, corr = 0, i_en high -> the center tap decays geometrically, with acc[3] after the first update = 2^21 - 2^9; zero taps stay 0.
6. Load: i_load idx = 5, val = 0x1C0 (-0.5) -> tap5 = 0x1C0 two clocks later. A simultaneous update on tap5 is discarded; idx = 7 is ignored.
